shift_add_mul_sequencer: RTL and testbench

//   Multi-cycle controller for unsigned multiplication with a start/done handshake.

---
 rtl/shift_add_mul_sequencer.sv | 104 ++++++++++
 tb/tb_shift_add_mul_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul_sequencer.sv
// Sequential unsigned shift-add multiplier with a start/done handshake.
// One SIZE-bit add per clock through a single shared adder; the product is held until the next completion.
module shift_add_mul_sequencer #(
    parameter int SIZE = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStart,
    input  logic [SIZE-1:0]   iA,
    input  logic [SIZE-1:0]   iB,
    output logic              oBusy,
    output logic              oDone,
    output logic [2*SIZE-1:0] oResult,
    output logic [1:0]        state_dbg
);

    // Handshake: iStart is a request that is only looked at in IDLE. The edge that
    // sees it captures iA/iB. oBusy stays high until the sequencer is back in IDLE.
    // oDone is a single-cycle pulse, and oResult is valid from that pulse onwards.
    // A request made while busy is dropped, not queued.

    localparam int CNT_W = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SIZE-1:0]     m_reg;
    logic [SIZE-1:0]     m_next;
    logic [2*SIZE-1:0]   p_reg;
    logic [2*SIZE-1:0]   p_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [2*SIZE-1:0]   result_reg;
    logic [2*SIZE-1:0]   result_next;
    logic [SIZE:0]       sum;
    logic [2*SIZE-1:0]   p_step;
    logic                last_step;

    // The adder is one bit wider than the operands so the carry lands in the shifted product.
    always_comb begin
        sum       = {1'b0, p_reg[2*SIZE-1:SIZE]} + (p_reg[0] ? {1'b0, m_reg} : '0);
        p_step    = {sum, p_reg[SIZE-1:1]};
        last_step = (cnt == CNT_W'(SIZE - 1));
    end

    always_comb begin
        state_next  = state;
        m_next      = m_reg;
        p_next      = p_reg;
        cnt_next    = cnt;
        result_next = result_reg;
        case (state)
            IDLE: begin
                if (iStart) begin
                    m_next     = iA;
                    p_next     = {{SIZE{1'b0}}, iB};
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                p_next   = p_step;
                cnt_next = cnt + CNT_W'(1);
                if (last_step) begin
                    result_next = p_step;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            m_reg      <= '0;
            p_reg      <= '0;
            cnt        <= '0;
            result_reg <= '0;
        end else begin
            state      <= state_next;
            m_reg      <= m_next;
            p_reg      <= p_next;
            cnt        <= cnt_next;
            result_reg <= result_next;
        end
    end

    assign oBusy     = (state != IDLE);
    assign oDone     = (state == DONE);
    assign oResult   = result_reg;
    assign state_dbg = state;

endmodule

// File: tb/tb_shift_add_mul_sequencer.sv
// Bench for shift_add_mul_sequencer: directed cases plus random operands, with every
// product predicted as plain A*B and matched to oDone pulses through an expected queue.
module tb_shift_add_mul_sequencer;
    localparam int SIZE = 8;
    localparam int W    = 2 * SIZE;

    logic            Clock;
    logic            Reset;
    logic            iStart;
    logic [SIZE-1:0] iA;
    logic [SIZE-1:0] iB;
    logic            oBusy;
    logic            oDone;
    logic [W-1:0]    oResult;
    logic [1:0]      state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_result;
    logic         prev_done;

    shift_add_mul_sequencer #(.SIZE(SIZE)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iStart   (iStart),
        .iA       (iA),
        .iB       (iB),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oResult  (oResult),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        int unsigned prod;
        prod = int'(a) * int'(b);
        return W'(prod);
    endfunction

    // scoreboard: every oDone consumes one expected product; result must hold between pulses
    always @(negedge Clock) begin
        if (Reset) begin
            exp_q.delete();
            last_result = '0;
            prev_done   = 1'b0;
        end else begin
            if (oDone) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", oDone, 1'b0);
                end else begin
                    last_result = exp_q.pop_front();
                    check_eq("result", oResult, last_result);
                    check_eq("done_width", prev_done, 1'b0);
                end
            end else begin
                check_eq("result_hold", oResult, last_result);
            end
            prev_done = oDone;
        end
    end

    // drivers: inputs change on the falling edge, outputs are sampled there too
    task automatic start_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        @(negedge Clock);
        iA     = a;
        iB     = b;
        iStart = 1'b1;
        exp_q.push_back(model_mul(a, b));
        @(negedge Clock);
        iStart = 1'b0;
        iA     = SIZE'($urandom);
        iB     = SIZE'($urandom);
        check_eq("busy_after_start", oBusy, 1'b1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!oDone && n < 100);
        if (!oDone) check_eq("done_timeout", oDone, 1'b1);
    endtask

    initial begin
        int n;
        int n2;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;

        Reset  = 1'b1;
        iStart = 1'b0;
        iA     = '0;
        iB     = '0;
        #1;
        check_eq("reset_busy", oBusy, 1'b0);
        check_eq("reset_done", oDone, 1'b0);
        check_eq("reset_result", oResult, 16'h0000);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // basic product and latency
        start_op(8'h0D, 8'h0B);
        wait_done(n);
        check_eq("t1_latency", n, SIZE);
        check_eq("t1_value", oResult, 16'h008F);

        // corner operands
        start_op(8'hFF, 8'hFF);
        wait_done(n);
        check_eq("t2_ffxff", oResult, 16'hFE01);
        start_op(8'h00, 8'hFF);
        wait_done(n);
        check_eq("t2_0xff", oResult, 16'h0000);
        start_op(8'h01, 8'h80);
        wait_done(n);
        check_eq("t2_1x80", oResult, 16'h0080);

        // iStart held high: back-to-back operations with operands changed after acceptance
        @(negedge Clock);
        iA     = 8'd3;
        iB     = 8'd5;
        iStart = 1'b1;
        exp_q.push_back(model_mul(8'd3, 8'd5));
        exp_q.push_back(model_mul(8'd200, 8'd100));
        @(negedge Clock);
        iA = 8'd200;
        iB = 8'd100;
        check_eq("t3_busy", oBusy, 1'b1);
        wait_done(n);
        check_eq("t3_first_latency", n, SIZE);
        check_eq("t3_first_value", oResult, 16'h000F);
        wait_done(n2);
        iStart = 1'b0;
        check_eq("t3_gap", n2, SIZE + 2);
        check_eq("t3_second_value", oResult, 16'h4E20);
        repeat (2) @(negedge Clock);
        check_eq("t3_idle", oBusy, 1'b0);

        // requests during RUN and during DONE are dropped
        start_op(8'h21, 8'h13);
        repeat (2) @(negedge Clock);
        iA     = 8'hAA;
        iB     = 8'h55;
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        wait_done(n);
        check_eq("t4_value", oResult, 16'h0273);
        iA     = 8'h77;
        iB     = 8'h66;
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        check_eq("t4_idle_after_done", oBusy, 1'b0);
        repeat (SIZE + 3) @(negedge Clock);
        check_eq("t4_still_idle", oBusy, 1'b0);

        // asynchronous reset in the middle of RUN
        start_op(8'h5A, 8'hC3);
        repeat (4) @(negedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("t5_busy", oBusy, 1'b0);
        check_eq("t5_done", oDone, 1'b0);
        check_eq("t5_result", oResult, 16'h0000);
        @(negedge Clock);
        #2;
        Reset = 1'b0;
        repeat (SIZE + 4) @(negedge Clock);
        check_eq("t5_no_done_idle", oBusy, 1'b0);
        start_op(8'h12, 8'h34);
        wait_done(n);
        check_eq("t5_restart_latency", n, SIZE);
        check_eq("t5_restart_value", oResult, 16'h03A8);

        // random operands, with a bias towards the extremes
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       a = '0;
                1:       a = '1;
                default: a = SIZE'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                default: b = SIZE'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge Clock);
            start_op(a, b);
            wait_done(n);
            check_eq("rand_latency", n, SIZE);
        end

        repeat (3) @(negedge Clock);
        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
